// File: rtl/spi2mem_master.sv
// spi2mem_master: SPI mode-0 master that reads one WIDTH-bit word from a
// memory-mapped SPI slave while shifting a WIDTH-bit word out on mosi.
// spi_clk and cs_n are derived from clk by dividing it down; each SPI
// half-period is CLK_DIV clk cycles.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-high
//   start    transfer request, sampled in IDLE and in the last GAP cycle
//   tx_data  word to send, latched when start is accepted
//   busy     high while a transfer is in flight
//   done     one-cycle pulse, rx_data valid from this cycle
//   rx_data  last complete received word
//   spi_clk  SPI clock (idles low), registered
//   cs_n     chip select, active-low, registered
//   mosi     serial data out, MSB first, registered
//   miso     serial data in, sampled on spi_clk rising edges
//
// state | meaning
// IDLE  | bus idle, waiting for start
// LEAD  | cs_n low, first bit on mosi, spi_clk low for one half-period
// SHIFT | spi_clk toggling; sample on rise, shift out on fall
// TRAIL | spi_clk low, cs_n still low for one half-period
// GAP   | cs_n high for CLK_DIV cycles so the slave can reload its snapshot

module spi2mem_master #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             spi_clk,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso
);

  localparam int HP_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BC_W = $clog2(WIDTH + 1);
  localparam logic [HP_W-1:0] HP_LAST = HP_W'(CLK_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_TRAIL,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [BC_W-1:0]  bc_q, bc_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             spi_clk_q, spi_clk_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [HP_W-1:0]  hp_next;
  logic             accept;

  always_comb begin
    state_d   = state_q;
    hp_d      = hp_q;
    bc_d      = bc_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    spi_clk_d = spi_clk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    accept    = 1'b0;
    hp_next   = (hp_q == HP_LAST) ? '0 : hp_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        cs_n_d    = 1'b1;
        spi_clk_d = 1'b0;
        mosi_d    = 1'b0;
        busy_d    = 1'b0;
        accept    = start;
      end
      S_LEAD: begin
        cs_n_d = 1'b0;
        busy_d = 1'b1;
        mosi_d = tx_q[WIDTH-1];
        hp_d   = hp_next;
        if (hp_q == HP_LAST) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        hp_d = hp_next;
        // spi_clk toggles on the first cycle of every half-period
        if (hp_q == '0) begin
          spi_clk_d = ~spi_clk_q;
          if (!spi_clk_q) begin
            rx_d = {rx_q[WIDTH-2:0], miso};
            bc_d = bc_q + 1'b1;
          end else if (bc_q == BC_LAST) begin
            // falling edge after the last sample closes the frame
            mosi_d  = 1'b0;
            state_d = S_TRAIL;
          end else begin
            tx_d   = tx_q << 1;
            mosi_d = tx_q[WIDTH-2];
          end
        end
      end
      S_TRAIL: begin
        hp_d = hp_next;
        if (hp_q == '0) begin
          cs_n_d  = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        hp_d = hp_next;
        if (hp_q == HP_LAST) begin
          rx_data_d = rx_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
          // a start in the done cycle chains directly, keeping cs_n high
          // for exactly CLK_DIV cycles between frames
          accept    = start;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      tx_d    = tx_data;
      rx_d    = '0;
      bc_d    = '0;
      hp_d    = '0;
      state_d = S_LEAD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hp_q      <= '0;
      bc_q      <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      spi_clk_q <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hp_q      <= hp_d;
      bc_q      <= bc_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      spi_clk_q <= spi_clk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign spi_clk = spi_clk_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi2mem_master.sv
// Testbench for spi2mem_master: two instances (16-bit/CLK_DIV 4 and
// 48-bit/CLK_DIV 2), each talking to a behavioural shift-out slave that
// snapshots its memory word when cs_n falls.

module tb_spi2mem_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        start16, busy16, done16, spi_clk16, cs_n16, mosi16, miso16;
  logic [15:0] tx16, rx16, mem16, sh16, cap16;
  logic        start48, busy48, done48, spi_clk48, cs_n48, mosi48, miso48;
  logic [47:0] tx48, rx48, mem48, sh48, cap48;

  int passed = 0, total = 0, fails = 0;
  int rises16 = 0, rises48 = 0, ndone16 = 0;
  int cyc = 0, cs_rise_cyc = 0, hi_len16 = -1;

  spi2mem_master #(.WIDTH(16), .CLK_DIV(4)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .tx_data(tx16),
    .busy(busy16), .done(done16), .rx_data(rx16), .spi_clk(spi_clk16),
    .cs_n(cs_n16), .mosi(mosi16), .miso(miso16)
  );

  spi2mem_master #(.WIDTH(48), .CLK_DIV(2)) dut48 (
    .clk(clk), .reset(reset), .start(start48), .tx_data(tx48),
    .busy(busy48), .done(done48), .rx_data(rx48), .spi_clk(spi_clk48),
    .cs_n(cs_n48), .mosi(mosi48), .miso(miso48)
  );

  // slave models: snapshot on cs_n fall, shift out on spi_clk fall
  always @(negedge cs_n16) begin sh16 = mem16; miso16 = mem16[15]; end
  always @(negedge spi_clk16) if (!cs_n16) begin sh16 = sh16 << 1; miso16 = sh16[15]; end
  always @(negedge cs_n48) begin sh48 = mem48; miso48 = mem48[47]; end
  always @(negedge spi_clk48) if (!cs_n48) begin sh48 = sh48 << 1; miso48 = sh48[47]; end

  // mosi capture and rise count per frame
  always @(negedge cs_n16) begin cap16 = '0; rises16 = 0; end
  always @(posedge spi_clk16) if (!cs_n16) begin cap16 = {cap16[14:0], mosi16}; rises16++; end
  always @(negedge cs_n48) begin cap48 = '0; rises48 = 0; end
  always @(posedge spi_clk48) if (!cs_n48) begin cap48 = {cap48[46:0], mosi48}; rises48++; end

  always @(posedge done16) ndone16++;
  always @(posedge clk) cyc++;
  always @(posedge cs_n16) cs_rise_cyc = cyc;
  always @(negedge cs_n16) hi_len16 = cyc - cs_rise_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Follows one frame whose start was accepted at the edge just before the
  // call. Expected timing comes from the frame arithmetic of the protocol.
  task automatic watch(input bit big, input logic [63:0] tx, input logic [63:0] exp_rx,
                       input logic [63:0] new_mem, input int inject_at, input string tag);
    int w, d, k, busy_drops, done_k;
    bit seen;
    logic cs, bsy, mo, sck, dn;
    logic [63:0] msk;
    w = big ? 48 : 16;
    d = big ? 2 : 4;
    msk = big ? 64'h0000_FFFF_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
    k = 0; seen = 0; busy_drops = 0; done_k = -1;
    while (!seen && k < 2 * d * (2 * w + 2) + 20) begin
      @(posedge clk);
      k++;
      #1;
      if (k == 20) begin
        if (big) mem48 = new_mem[47:0];
        else mem16 = new_mem[15:0];
      end
      if (k == inject_at) begin if (big) start48 = 1'b1; else start16 = 1'b1; end
      if (k == inject_at + 1) begin start48 = 1'b0; start16 = 1'b0; end
      cs  = big ? cs_n48 : cs_n16;
      bsy = big ? busy48 : busy16;
      mo  = big ? mosi48 : mosi16;
      sck = big ? spi_clk48 : spi_clk16;
      dn  = big ? done48 : done16;
      if (k == 1) check({tag, "_lead"}, {60'd0, cs, bsy, mo, sck}, {60'd0, 1'b0, 1'b1, tx[w-1], 1'b0});
      if (k == 2 * w * d + 1) check({tag, "_trail"}, {62'd0, cs, mo}, 64'd0);
      if (k == d * (2 * w + 1) + 1) check({tag, "_cs_rise"}, {63'd0, cs}, 64'd1);
      if (dn) begin
        seen = 1;
        done_k = k;
      end else if (!bsy) begin
        busy_drops++;
      end
    end
    check({tag, "_done_time"}, done_k, d * (2 * w + 2));
    check({tag, "_rx"}, (big ? {16'd0, rx48} : {48'd0, rx16}), exp_rx & msk);
    check({tag, "_mosi_bits"}, (big ? {16'd0, cap48} : {48'd0, cap16}), tx & msk);
    check({tag, "_rises"}, (big ? rises48 : rises16), w);
    check({tag, "_busy"}, busy_drops, 0);
  endtask

  task automatic xfer(input bit big, input logic [63:0] tx, input logic [63:0] mem,
                      input logic [63:0] new_mem, input bit hold, input int inject_at,
                      input string tag);
    @(negedge clk);
    if (big) begin mem48 = mem[47:0]; tx48 = tx[47:0]; start48 = 1'b1; end
    else begin mem16 = mem[15:0]; tx16 = tx[15:0]; start16 = 1'b1; end
    @(posedge clk);
    #1;
    if (!hold) begin start16 = 1'b0; start48 = 1'b0; end
    watch(big, tx, mem, new_mem, inject_at, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [63:0] r, m;
    int n0, g;
    reset = 1'b1;
    start16 = 1'b0; start48 = 1'b0;
    tx16 = '0; tx48 = '0; mem16 = '0; mem48 = '0;
    miso16 = 1'b0; miso48 = 1'b0; sh16 = '0; sh48 = '0; cap16 = '0; cap48 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs16", {58'd0, cs_n16, spi_clk16, mosi16, busy16, done16, 1'b0}, 64'b100000);
    check("reset_rx16", rx16, 16'h0);
    check("reset_rx48", rx48, 48'h0);
    @(negedge clk) reset = 1'b0;

    // basic
    xfer(0, 64'h3C81, 64'hA55A, 64'hA55A, 0, -1, "basic");

    // start pulse mid-transfer must be ignored
    n0 = ndone16;
    xfer(0, 64'h1234, 64'hBEEF, 64'hBEEF, 0, 10, "ign");
    repeat (20) @(posedge clk);
    #1;
    check("ign_single_done", ndone16 - n0, 1);
    check("ign_idle_after", {63'd0, busy16}, 64'd0);

    // back-to-back with start held; memory changes during the first frame
    n0 = ndone16;
    xfer(0, 64'h3C81, 64'hA55A, 64'h0F43, 1, -1, "b2b1");
    start16 = 1'b0;
    watch(0, 64'h3C81, 64'h0F43, 64'h0F43, -1, "b2b2");
    check("b2b_cs_high", hi_len16, 4);
    check("b2b_done_count", ndone16 - n0, 2);

    // reset after the 5th rising edge
    @(negedge clk);
    mem16 = 16'h5A5A; tx16 = 16'hC3C3; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    @(posedge clk);
    #1;
    g = 0;
    while (rises16 < 5 && g < 200) begin @(posedge clk); #1; g++; end
    check("rst_rises", rises16, 5);
    #2 reset = 1'b1;
    #1;
    check("rst_outs16", {58'd0, cs_n16, spi_clk16, mosi16, busy16, done16, 1'b0}, 64'b100000);
    check("rst_rx16", rx16, 16'h0);
    @(negedge clk) reset = 1'b0;
    xfer(0, 64'h6DB6, 64'hA55A, 64'hA55A, 0, -1, "post_rst");

    // all-ones then all-zeros
    xfer(0, 64'h0001, 64'hFFFF, 64'hFFFF, 0, -1, "ones");
    xfer(0, 64'hFFFE, 64'h0000, 64'h0000, 0, -1, "zeros");

    // wide/fast
    xfer(1, 64'h8000_0000_0001, 64'h01AA55000F43, 64'h01AA55000F43, 0, -1, "wide");

    // random frames on both instances
    for (int i = 0; i < 4; i++) begin
      r = {32'd0, $urandom};
      m = {32'd0, $urandom};
      xfer(0, r, m, m, 0, -1, "rnd16");
    end
    for (int i = 0; i < 2; i++) begin
      r = {$urandom, $urandom};
      m = {$urandom, $urandom};
      r[63:48] = '0;
      m[63:48] = '0;
      xfer(1, r, m, m, 0, -1, "rnd48");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi2mem_master.md
# spi2mem_master

SPI master that reads a WIDTH-bit word from a memory-mapped SPI slave (the `mem2spi_slave` shift-out register) while shifting a WIDTH-bit word out on MOSI. It sits in the system clock domain of the controller FPGA. It generates `spi_clk` and `cs_n` by division of `clk`, and returns the captured word on a start/done handshake. The block drives SPI mode 0: `spi_clk` idles low, MSB first, the slave changes data on falling edges, and the master samples on rising edges.

## Interface
- `WIDTH`, default 16: transfer length in bits (≥2).
- `CLK_DIV`, default 4: `clk` cycles per SPI half-period (≥2).

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `start` in 1: transfer request, sampled only in IDLE.
- `tx_data` in WIDTH: word shifted out on `mosi`; latched when `start` is accepted.
- `busy` out 1: high from the cycle after acceptance until the `done` cycle (exclusive).
- `done` out 1: one-cycle pulse; `rx_data` is valid from this cycle.
- `rx_data` out WIDTH: last complete received word; holds until the next `done`.
- `spi_clk` out 1: SPI clock, registered.
- `cs_n` out 1: chip select, active-low, registered.
- `mosi` out 1: serial data out, registered.
- `miso` in 1: serial data in, from the slave.

## Operation
States: IDLE, LEAD, SHIFT, TRAIL, GAP.
- **IDLE:** `cs_n`=1, `spi_clk`=0, `mosi`=0, `busy`=0. When `start`=1:
  - latch `tx_data` into the tx shift register;
  - clear the rx shift register and the bit counter;
  - go to LEAD.
- **LEAD:** `cs_n`=0, `mosi`=tx MSB, `spi_clk`=0 for one half-period. Then enter SHIFT.
- **SHIFT:** `spi_clk` toggles every CLK_DIV cycles.
  - Rising edge: shift `miso` into the rx register LSB (`rx <= {rx[WIDTH-2:0], miso}`) and increment the bit counter.
  - Falling edge: shift the tx register left; `mosi` takes the next bit.
  - After the WIDTH-th rising edge, one more falling edge occurs. At that edge `mosi` goes to 0, and the state goes to TRAIL.
- **TRAIL:** `spi_clk`=0 and `cs_n`=0 for one half-period. Then `cs_n`=1 and go to GAP.
- **GAP:** `cs_n`=1 for CLK_DIV cycles. This is the minimum high time for the slave to reload its memory snapshot. On the last GAP cycle:
  - `rx_data` <= rx register;
  - `done` is pulsed;
  - `busy` falls;
  - the state goes to IDLE.
- `start` while busy is ignored; no queuing.
- `miso` is sampled with no synchronizer. This is legal because the slave is clocked by our `spi_clk`, and `miso` is stable for ≥ CLK_DIV−1 `clk` cycles before each sample.
- Bit counter width is clog2(WIDTH+1). The half-period counter is clog2(CLK_DIV) wide and wraps at CLK_DIV−1.

## Timing
Start is accepted at edge t0. All of the following are `clk` edges after t0.
- `cs_n` falls, `busy` rises, `mosi` = `tx_data[WIDTH-1]`: t0+1.
- k-th `spi_clk` rise (k = 0..WIDTH−1): t0+1+CLK_DIV·(2k+1). `miso` is sampled at this same edge.
- k-th fall (k = 0..WIDTH−1): t0+1+CLK_DIV·(2k+2).
  - `mosi` = `tx_data[WIDTH-2-k]` for k < WIDTH−1.
  - `mosi` = 0 after the last fall.
- `cs_n` rises: t0+1+CLK_DIV·(2·WIDTH+1).
- `done` pulse, `rx_data` update, `busy`=0: t0+CLK_DIV·(2·WIDTH+2).
- A `start` asserted in the `done` cycle is accepted. `cs_n` then falls at the next edge, giving a guaranteed `cs_n` high time of ≥ CLK_DIV cycles.

Reset (asynchronous), at any time including mid-transfer:
- State IDLE.
- `cs_n`=1, `spi_clk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0.
- Shift registers and counters cleared; the partial word is discarded.
- After reset release, the first accepted `start` performs a full, clean transfer.

## Test plan
- **Basic read/write.** Bench: WIDTH=16, CLK_DIV=4; `mem2spi_slave` memory=16'hA55A; `tx_data`=16'h3C81; pulse `start`.
  - `rx_data`=16'hA55A with `done` at t0+136.
  - Bits captured from `mosi` on `spi_clk` rises = 16'h3C81.
  - Exactly 16 `spi_clk` rises while `cs_n`=0.
- **Ignored start.** Pulse `start` again 10 cycles into the transfer → no effect; a single `done`; `busy` continuous.
- **Back-to-back.** Hold `start`=1 for two transfers while memory changes 16'hA55A → 16'h0F43 during the first.
  - Second `rx_data`=16'h0F43.
  - `cs_n` high for exactly CLK_DIV cycles between transfers.
- **Reset mid-transfer.** Assert `reset` after the 5th rising edge.
  - Outputs go immediately to reset values.
  - The next transfer returns the slave memory correctly (16'hA55A).
- **Wide/fast configuration.** WIDTH=48, CLK_DIV=2, memory=48'h01AA55000F43 → `rx_data`=48'h01AA55000F43, `done` at t0+196.
- **All-ones/all-zeros.** Memory 16'hFFFF then 16'h0000 → exact values returned; no stale bit from the previous transfer.
